// File: rtl/key_pkg.sv
// Shared constants and FSM encoding for the user-key debouncer.
package key_pkg;

  localparam int   KEY_WIDTH    = 8;
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One key: two-flop synchroniser, STABLE/COUNTING filter FSM, persistence
// counter and registered press/release pulses.
module debounce_bit
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_W         = 18
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic press_next,
  output logic release_next,
  output logic state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic             s1;
  logic             s2;
  db_state_e        cur_state;
  db_state_e        nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             out_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= KEY_RELEASED;
      s2 <= KEY_RELEASED;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cur_state   <= DB_STABLE;
      cnt         <= '0;
      key_out     <= KEY_RELEASED;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      cnt         <= cnt_next;
      key_out     <= out_next;
      key_press   <= press_next;
      key_release <= release_next;
    end
  end

  // Acceptance copies s2 into key_out; the pulse direction follows the new level.
  always_comb begin
    nxt_state    = cur_state;
    cnt_next     = cnt;
    out_next     = key_out;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (cur_state)
      DB_STABLE: begin
        if (s2 != key_out) begin
          if (STABLE_CYCLES == 1) begin
            out_next     = s2;
            cnt_next     = '0;
            press_next   = ~s2;
            release_next = s2;
          end else begin
            nxt_state = DB_COUNTING;
            cnt_next  = ONE_CNT;
          end
        end else begin
          cnt_next = '0;
        end
      end
      DB_COUNTING: begin
        if (s2 == key_out) begin
          nxt_state = DB_STABLE;
          cnt_next  = '0;
        end else if (cnt == LAST_CNT) begin
          nxt_state    = DB_STABLE;
          cnt_next     = '0;
          out_next     = s2;
          press_next   = ~s2;
          release_next = s2;
        end else begin
          cnt_next = cnt + ONE_CNT;
        end
      end
      default: begin
        nxt_state = DB_STABLE;
        cnt_next  = '0;
      end
    endcase
  end

  assign state = (cur_state == DB_COUNTING);

endmodule

// File: rtl/key_debouncer.sv
// Debounces WIDTH active-low user keys and reports per-key press/release
// pulses plus a single combined event strobe aligned with them.
module key_debouncer
  import key_pkg::*;
#(
  parameter int WIDTH         = KEY_WIDTH,
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_W         = 18
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] raw_key,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic             key_event,
  output logic [WIDTH-1:0] db_state
);

  logic [WIDTH-1:0] press_next;
  logic [WIDTH-1:0] release_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk         (clk),
      .clr         (clr),
      .raw         (raw_key[i]),
      .key_out     (key_out[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .press_next  (press_next[i]),
      .release_next(release_next[i]),
      .state       (db_state[i])
    );
  end

  // Built from the next-state pulse terms so it lands on the same edge as the bits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_event <= 1'b0;
    end else begin
      key_event <= |(press_next | release_next);
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with STABLE_CYCLES=4, CNT_W=3.
module tb_key_debouncer;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] raw_key = '1;
  logic [W-1:0] key_out;
  logic [W-1:0] key_press;
  logic [W-1:0] key_release;
  logic         key_event;
  logic [W-1:0] db_state;

  int checks = 0;
  int errors = 0;

  // reference model: a key accepts a new level once the last SC synchronised
  // samples all disagree with the current debounced level
  logic [W-1:0] m_s1, m_s2, m_out, m_press, m_rel;
  logic         m_evt;
  logic [W-1:0] m_win[SC];

  key_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(3)) dut (
    .clk        (clk),
    .clr        (clr),
    .raw_key    (raw_key),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release),
    .key_event  (key_event),
    .db_state   (db_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_out = '1; m_press = '0; m_rel = '0; m_evt = 1'b0;
    for (int k = 0; k < SC; k++) m_win[k] = '1;
  endtask

  task automatic model_edge();
    logic [W-1:0] acc;
    for (int k = SC - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_s2;
    acc = '1;
    for (int k = 0; k < SC; k++) acc &= (m_win[k] ^ m_out);
    m_press = acc & m_out;
    m_rel   = acc & ~m_out;
    m_evt   = |acc;
    m_out   = m_out ^ acc;
    m_s2    = m_s1;
    m_s1    = raw_key;
  endtask

  task automatic check_all();
    check("key_out", 32'(key_out), 32'(m_out));
    check("key_press", 32'(key_press), 32'(m_press));
    check("key_release", 32'(key_release), 32'(m_rel));
    check("key_event", 32'(key_event), 32'(m_evt));
    check("db_state", 32'(db_state), 32'(m_win[0] ^ m_out));
  endtask

  task automatic step();
    @(posedge clk);
    if (clr) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    // 1: reset with all keys held low
    raw_key = 8'h00;
    clr = 1'b1;
    repeat (3) step();
    check("reset_out", 32'(key_out), 32'hFF);
    clr = 1'b0;
    repeat (5) step();
    check("rst_press_early", 32'(key_press), 32'h00);
    step();
    check("rst_out_e6", 32'(key_out), 32'h00);
    check("rst_press_e6", 32'(key_press), 32'hFF);
    check("rst_event_e6", 32'(key_event), 32'h1);
    raw_key = 8'hFF;
    repeat (8) step();

    // 2: clean press/release of bit 2
    raw_key = 8'hFB;
    repeat (5) step();
    check("p2_not_early", 32'(key_out), 32'hFF);
    step();
    check("p2_out", 32'(key_out), 32'hFB);
    check("p2_press", 32'(key_press), 32'h04);
    step();
    check("p2_press_width", 32'(key_press), 32'h00);
    raw_key = 8'hFF;
    repeat (6) step();
    check("r2_release", 32'(key_release), 32'h04);
    repeat (3) step();

    // 3: bounce on bit 0, then settle low
    for (int i = 0; i < 10; i++) begin
      raw_key[0] = ~raw_key[0];
      repeat (2) step();
    end
    check("bounce_quiet", 32'(key_out), 32'hFF);
    raw_key = 8'hFE;
    repeat (6) step();
    check("bounce_press", 32'(key_press), 32'h01);
    raw_key = 8'hFF;
    repeat (8) step();

    // 4: simultaneous press of bit 7 and release of bit 1
    raw_key = 8'hFD;
    repeat (8) step();
    raw_key = 8'h7F;
    repeat (6) step();
    check("sim_press", 32'(key_press), 32'h80);
    check("sim_release", 32'(key_release), 32'h02);
    check("sim_event", 32'(key_event), 32'h1);
    raw_key = 8'hFF;
    repeat (8) step();

    // 5: clear in the middle of a bit-5 count
    raw_key = 8'hDF;
    repeat (4) step();
    clr = 1'b1;
    #1;
    model_reset();
    check("clr_async_out", 32'(key_out), 32'hFF);
    check("clr_async_state", 32'(db_state), 32'h00);
    repeat (2) step();
    clr = 1'b0;
    repeat (5) step();
    check("clr_not_early", 32'(key_out), 32'hFF);
    step();
    check("clr_reaccept", 32'(key_press), 32'h20);
    raw_key = 8'hFF;
    repeat (8) step();

    // 6: threshold boundary on bit 4
    raw_key = 8'hEF;
    repeat (3) step();
    raw_key = 8'hFF;
    repeat (8) step();
    check("thr3_none", 32'(key_out), 32'hFF);
    raw_key = 8'hEF;
    repeat (4) step();
    raw_key = 8'hFF;
    repeat (2) step();
    check("thr4_press", 32'(key_press), 32'h10);
    repeat (4) step();
    check("thr4_release", 32'(key_release), 32'h10);
    repeat (4) step();

    // randomized: per-key flips with varied hold times, occasional clear
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] flip;
      flip = '0;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
      raw_key = raw_key ^ flip;
      if ($urandom_range(0, 150) == 0) begin
        clr = 1'b1;
        #1;
        model_reset();
        check("rand_clr_out", 32'(key_out), 32'hFF);
        step();
        clr = 1'b0;
      end
      repeat ($urandom_range(1, 6)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
